pc_seq: RTL and testbench
=========================

Name: pc_seq

Overview:
- Program-counter sequencer for the one-cycle CPU.
- Owns the instruction address fed to program memory and decides when the core may execute: run / halt / single-step.
- Resolves branch ops decoded by cpu_ctrl (JMP, JZ, JNZ, CALL, RET) using the accumulator Z flag.
- Holds a small hardware return stack; gates cpu_ctrl write enables through EXEC_EN.

Parameters:
- PC_WIDTH, 8, program address width (matches IMM/D_MEM_ADDR field width WIDTH-IWIDTH).
- STACK_DEPTH, 4, return-stack entries (power of two, >=2).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- RUN  in  1  level request: start or continue free-running execution.
- STEP  in  1  pulse while halted: execute exactly one instruction.
- HALT_REQ  in  1  request to stop after the current instruction.
- BR_OP  in  3  branch op from cpu_ctrl: 000 NOP, 001 JMP, 010 JZ, 011 JNZ, 100 CALL, 101 RET, 11x reserved (treated as NOP).
- BR_TARGET  in  PC_WIDTH  branch/call target (cpu_ctrl IMM field).
- Z  in  1  accumulator zero flag, valid in the executing cycle.
- PC  out  PC_WIDTH  current instruction address.
- EXEC_EN  out  1  high in cycles where the fetched instruction commits; cpu_ctrl ANDs it into EN_ACC, EN_REG_F, EN_D_MEM.
- HALTED  out  1  high in HALTED state.
- FAULT  out  1  sticky stack overflow/underflow indication.
- STACK_LVL  out  clog2(STACK_DEPTH)+1  number of valid return-stack entries.

Behaviour:
- Reset (RSTN low, async): PC=RESET_PC, state HALTED, EXEC_EN=0, HALTED=1, FAULT=0, STACK_LVL=0. Stack contents are don't-care.
- FSM states and outputs:
  - HALTED: EXEC_EN=0.
  - RUNNING: EXEC_EN=1.
  - STEP_ONE: EXEC_EN=1.
  - FAULTED: EXEC_EN=0, FAULT=1.
- EXEC_EN and HALTED are decoded from the state register only; no combinational path from RUN/STEP/HALT_REQ.
- Transitions, evaluated at each rising edge:
  - HALTED: RUN=1 -> RUNNING; else STEP=1 -> STEP_ONE; else stay. RUN has priority over STEP.
  - RUNNING: HALT_REQ=1 or RUN=0 -> HALTED. The instruction in that cycle still commits and PC advances.
  - STEP_ONE: -> HALTED unconditionally. Exactly one commit per STEP, even if STEP is held high; a new step needs STEP low for at least one HALTED cycle.
  - Any executing state: stack error -> FAULTED.
  - FAULTED: absorbing; exits only via reset.
- PC update happens only when EXEC_EN=1; otherwise PC holds. Arithmetic is modulo 2^PC_WIDTH, so PC+1 wraps from all-ones to 0.
  - NOP/reserved: PC+1.
  - JMP: BR_TARGET.
  - JZ: Z ? BR_TARGET : PC+1.
  - JNZ: !Z ? BR_TARGET : PC+1.
  - CALL: push PC+1, then PC=BR_TARGET. Overflow when STACK_LVL==STACK_DEPTH.
  - RET: PC=top, pop. Underflow when STACK_LVL==0.
- Stack error: PC, stack and STACK_LVL are unchanged; FAULT is set on the same edge; the faulting instruction is still at PC for debug.
- CALL at PC=all-ones pushes 0 (wrapped return address).
- Latency: PC for the next instruction is valid one cycle after the executing cycle; zero bubbles in RUNNING.
- Z is ignored for all ops except JZ/JNZ.

Optional Feature:
- Macro PC_SEQ_CALL_STACK_EN.
- Defined: return stack, CALL/RET, STACK_LVL and the FAULT logic as above.
- Undefined:
  - No stack storage.
  - CALL behaves as JMP; RET behaves as NOP (PC+1).
  - STACK_LVL ties to 0, FAULT ties to 0, and FAULTED is unreachable.

Decomposition:
- Shared package cpu_pkg holds:
  - BR_OP encodings: BR_NOP, BR_JMP, BR_JZ, BR_JNZ, BR_CALL, BR_RET.
  - FSM state encoding: ST_HALTED, ST_RUNNING, ST_STEP_ONE, ST_FAULTED.
  - Default PC_WIDTH=8.
- One sub-module, ret_stack: a LIFO with push, pop, top, level, full and empty. pc_seq keeps the FSM and next-PC mux.

Test Plan:
- Reset, then RUN=1 with BR_OP=NOP for 300 cycles -> PC counts 0..255, wraps to 0, EXEC_EN=1 throughout. Reset asserted mid-run forces PC=0, HALTED=1 asynchronously.
- Halted at PC=5, STEP held high for 3 cycles -> exactly one commit, PC=6, HALTED=1. Drop STEP, pulse again -> PC=7.
- RUNNING at PC=10, BR_OP=JZ, BR_TARGET=40: Z=1 -> PC=40. Repeat with Z=0 -> PC=11. JNZ gives the mirrored results.
- CALL 0x20 at PC=3, then CALL 0x30 at 0x20, then RET, then RET -> PC sequence 0x20, 0x30, 0x21, 4; STACK_LVL 1, 2, 1, 0.
- Five nested CALLs with STACK_DEPTH=4 -> fifth CALL sets FAULT=1, PC stays at the fifth CALL's address, EXEC_EN=0 until reset. Separately, RET with an empty stack -> FAULT=1.
- RUNNING with HALT_REQ=1 at PC=8 with JMP 50 -> jump commits, PC=50, HALTED=1 next cycle, EXEC_EN=0. Build without PC_SEQ_CALL_STACK_EN: CALL 0x20 -> PC=0x20, RET -> PC+1, FAULT stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the one-cycle CPU (branch ops, sequencer states, default widths)
package cpu_pkg;

    localparam int DEF_PC_WIDTH = 8;

    typedef enum logic [2:0] {
        BR_NOP  = 3'b000,
        BR_JMP  = 3'b001,
        BR_JZ   = 3'b010,
        BR_JNZ  = 3'b011,
        BR_CALL = 3'b100,
        BR_RET  = 3'b101
    } br_op_t;

    typedef enum logic [1:0] {
        ST_HALTED,
        ST_RUNNING,
        ST_STEP_ONE,
        ST_FAULTED
    } seq_state_t;

endpackage

// File: rtl/ret_stack.sv
// ret_stack: LIFO of return addresses
//   CLK/RSTN  clock, async active-low reset (clears level only; contents are don't-care)
//   push/pop  one operation per cycle; caller never pushes when full nor pops when empty
//   din/top   pushed value / most recently pushed value
//   level     valid entries; full/empty derived from it
module ret_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              din,
    output logic [W-1:0]              top,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      full,
    output logic                      empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN)
            level <= '0;
        else
            level <= push ? level + 1'b1 : pop ? level - 1'b1 : level;

    always_ff @(posedge CLK)
        if (push)
            mem[level[AW-1:0]] <= din;

    // low bits wrap: level==DEPTH addresses entry DEPTH-1
    assign top   = mem[level[AW-1:0] - AW'(1)];
    assign full  = level == ($clog2(DEPTH) + 1)'(DEPTH);
    assign empty = level == '0;

endmodule

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer with run/halt/single-step control and return stack
//   CLK, RSTN                  clock, async active-low reset
//   RUN, STEP, HALT_REQ        execution control requests
//   BR_OP, BR_TARGET, Z        branch op, target and accumulator zero flag
//   PC                         instruction address
//   EXEC_EN, HALTED, FAULT     state-decoded status
//   STACK_LVL                  valid return-stack entries
// Build option: PC_SEQ_CALL_STACK_EN enables the return stack, CALL/RET and stack faults;
// without it CALL acts as JMP, RET as NOP, and FAULT/STACK_LVL are tied to 0.
module pc_seq import cpu_pkg::*; #(
    parameter int                    PC_WIDTH    = DEF_PC_WIDTH,
    parameter int                    STACK_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic                          RUN,
    input  logic                          STEP,
    input  logic                          HALT_REQ,
    input  logic [2:0]                    BR_OP,
    input  logic [PC_WIDTH-1:0]           BR_TARGET,
    input  logic                          Z,
    output logic [PC_WIDTH-1:0]           PC,
    output logic                          EXEC_EN,
    output logic                          HALTED,
    output logic                          FAULT,
    output logic [$clog2(STACK_DEPTH):0]  STACK_LVL
);
    seq_state_t          st;
    logic                step_arm;
    logic                stk_err;
    logic                take;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pc_nxt;

    assign EXEC_EN = st == ST_RUNNING || st == ST_STEP_ONE;
    assign HALTED  = st == ST_HALTED;
    assign pc_inc  = PC + PC_WIDTH'(1);
    // CALL redirects like JMP in both builds; only the stack side differs
    assign take    = BR_OP == BR_JMP || BR_OP == BR_CALL || (BR_OP == BR_JZ && Z) || (BR_OP == BR_JNZ && !Z);

`ifdef PC_SEQ_CALL_STACK_EN
    logic                is_call;
    logic                is_ret;
    logic                full;
    logic                empty;
    logic [PC_WIDTH-1:0] top;

    assign is_call = BR_OP == BR_CALL;
    assign is_ret  = BR_OP == BR_RET;
    assign stk_err = EXEC_EN && ((is_call && full) || (is_ret && empty));
    assign pc_nxt  = is_ret ? top : take ? BR_TARGET : pc_inc;
    assign FAULT   = st == ST_FAULTED;

    ret_stack #(.W(PC_WIDTH), .DEPTH(STACK_DEPTH)) u_stack (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .push  (EXEC_EN && is_call && !full),
        .pop   (EXEC_EN && is_ret && !empty),
        .din   (pc_inc),
        .top   (top),
        .level (STACK_LVL),
        .full  (full),
        .empty (empty)
    );
`else
    assign stk_err   = 1'b0;
    assign pc_nxt    = take ? BR_TARGET : pc_inc;
    assign FAULT     = 1'b0;
    assign STACK_LVL = '0;
`endif

    // step_arm: STEP must be seen low in HALTED before another step is accepted
    always_ff @(posedge CLK or negedge RSTN)
        if (!RSTN) begin
            st       <= ST_HALTED;
            PC       <= RESET_PC;
            step_arm <= 1'b1;
        end else begin
            case (st)
                ST_HALTED: begin
                    step_arm <= !STEP;
                    st       <= RUN ? ST_RUNNING : (STEP && step_arm) ? ST_STEP_ONE : ST_HALTED;
                end
                ST_RUNNING, ST_STEP_ONE: begin
                    PC <= stk_err ? PC : pc_nxt;
                    st <= stk_err ? ST_FAULTED
                        : (st == ST_STEP_ONE || HALT_REQ || !RUN) ? ST_HALTED : ST_RUNNING;
                end
                default: st <= ST_FAULTED;
            endcase
        end

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed tests for pc_seq (reset, free run, step, branches, call/ret, faults, halt)
module tb_pc_seq;
    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       RUN = 1'b0;
    logic       STEP = 1'b0;
    logic       HALT_REQ = 1'b0;
    logic [2:0] BR_OP = 3'b000;
    logic [7:0] BR_TARGET = 8'h00;
    logic       Z = 1'b0;
    logic [7:0] PC;
    logic       EXEC_EN;
    logic       HALTED;
    logic       FAULT;
    logic [2:0] STACK_LVL;
    logic [13:0] obs;
    logic [13:0] exp_v;
    int checks = 0;
    int errors = 0;

    pc_seq #(.PC_WIDTH(8), .STACK_DEPTH(4), .RESET_PC(8'h00)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .RUN       (RUN),
        .STEP      (STEP),
        .HALT_REQ  (HALT_REQ),
        .BR_OP     (BR_OP),
        .BR_TARGET (BR_TARGET),
        .Z         (Z),
        .PC        (PC),
        .EXEC_EN   (EXEC_EN),
        .HALTED    (HALTED),
        .FAULT     (FAULT),
        .STACK_LVL (STACK_LVL)
    );

    always #5 CLK = ~CLK;

    assign obs = {PC, EXEC_EN, HALTED, FAULT, STACK_LVL};

    function automatic logic [13:0] ev(input logic [7:0] p, input logic e, input logic h, input logic f, input logic [2:0] l);
        return {p, e, h, f, l};
    endfunction

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        RUN = 1'b0;
        STEP = 1'b0;
        HALT_REQ = 1'b0;
        BR_OP = 3'b000;
        BR_TARGET = 8'h00;
        Z = 1'b0;
        tick();
        RSTN = 1'b1;
    endtask

    task automatic start_run();
        RUN = 1'b1;
        BR_OP = 3'b000;
        tick();
    endtask

    task automatic jmp(input logic [7:0] p);
        BR_OP = 3'b001;
        BR_TARGET = p;
        tick();
        BR_OP = 3'b000;
    endtask

    task automatic op(input logic [2:0] o, input logic [7:0] t, input logic zf);
        BR_OP = o;
        BR_TARGET = t;
        Z = zf;
        tick();
        BR_OP = 3'b000;
        Z = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        exp_v = ev(8'h00, 0, 1, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL reset got %h want %h", obs, exp_v); end
    endtask

    task automatic test_free_run();
        do_reset();
        start_run();
        exp_v = ev(8'h00, 1, 0, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL run_start got %h want %h", obs, exp_v); end
        for (int i = 1; i <= 300; i++) begin
            tick();
            exp_v = ev(i[7:0], 1, 0, 0, 0);
            checks++; if (obs !== exp_v) begin errors++; $display("FAIL run_%0d got %h want %h", i, obs, exp_v); end
        end
        #2 RSTN = 1'b0;
        #1;
        exp_v = ev(8'h00, 0, 1, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL async_reset got %h want %h", obs, exp_v); end
        RUN = 1'b0;
        tick();
        RSTN = 1'b1;
    endtask

    task automatic test_step();
        do_reset();
        RUN = 1'b1;
        BR_OP = 3'b001;
        BR_TARGET = 8'd5;
        tick();
        HALT_REQ = 1'b1;
        tick();
        exp_v = ev(8'd5, 0, 1, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL step_setup got %h want %h", obs, exp_v); end
        RUN = 1'b0;
        HALT_REQ = 1'b0;
        BR_OP = 3'b000;
        STEP = 1'b1;
        tick();
        exp_v = ev(8'd5, 1, 0, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL step_one got %h want %h", obs, exp_v); end
        tick();
        exp_v = ev(8'd6, 0, 1, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL step_commit got %h want %h", obs, exp_v); end
        tick();
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL step_held got %h want %h", obs, exp_v); end
        STEP = 1'b0;
        tick();
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL step_low got %h want %h", obs, exp_v); end
        STEP = 1'b1;
        tick();
        STEP = 1'b0;
        tick();
        exp_v = ev(8'd7, 0, 1, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL step_again got %h want %h", obs, exp_v); end
    endtask

    task automatic test_branch();
        do_reset();
        start_run();
        jmp(8'd10);
        exp_v = ev(8'd10, 1, 0, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL jmp10 got %h want %h", obs, exp_v); end
        op(3'b010, 8'd40, 1'b1);
        checks++; if (PC !== 8'd40) begin errors++; $display("FAIL jz_taken got %0d want 40", PC); end
        jmp(8'd10);
        op(3'b010, 8'd40, 1'b0);
        checks++; if (PC !== 8'd11) begin errors++; $display("FAIL jz_not got %0d want 11", PC); end
        jmp(8'd10);
        op(3'b011, 8'd40, 1'b0);
        checks++; if (PC !== 8'd40) begin errors++; $display("FAIL jnz_taken got %0d want 40", PC); end
        jmp(8'd10);
        op(3'b011, 8'd40, 1'b1);
        checks++; if (PC !== 8'd11) begin errors++; $display("FAIL jnz_not got %0d want 11", PC); end
        op(3'b110, 8'd40, 1'b1);
        checks++; if (PC !== 8'd12) begin errors++; $display("FAIL rsv110 got %0d want 12", PC); end
        op(3'b111, 8'd40, 1'b0);
        checks++; if (PC !== 8'd13) begin errors++; $display("FAIL rsv111 got %0d want 13", PC); end
        op(3'b001, 8'h99, 1'b1);
        checks++; if (PC !== 8'h99) begin errors++; $display("FAIL jmp_z got %h want 99", PC); end
    endtask

`ifdef PC_SEQ_CALL_STACK_EN
    task automatic test_call_ret();
        do_reset();
        start_run();
        jmp(8'd3);
        op(3'b100, 8'h20, 1'b0);
        exp_v = ev(8'h20, 1, 0, 0, 1);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL call1 got %h want %h", obs, exp_v); end
        op(3'b100, 8'h30, 1'b0);
        exp_v = ev(8'h30, 1, 0, 0, 2);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL call2 got %h want %h", obs, exp_v); end
        op(3'b101, 8'h00, 1'b0);
        exp_v = ev(8'h21, 1, 0, 0, 1);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL ret1 got %h want %h", obs, exp_v); end
        op(3'b101, 8'h00, 1'b0);
        exp_v = ev(8'h04, 1, 0, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL ret2 got %h want %h", obs, exp_v); end
        jmp(8'hFF);
        op(3'b100, 8'h10, 1'b0);
        op(3'b101, 8'h00, 1'b0);
        exp_v = ev(8'h00, 1, 0, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL call_wrap got %h want %h", obs, exp_v); end
    endtask

    task automatic test_faults();
        do_reset();
        start_run();
        jmp(8'd1);
        op(3'b100, 8'h10, 1'b0);
        op(3'b100, 8'h20, 1'b0);
        op(3'b100, 8'h30, 1'b0);
        op(3'b100, 8'h40, 1'b0);
        exp_v = ev(8'h40, 1, 0, 0, 4);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL call4 got %h want %h", obs, exp_v); end
        op(3'b100, 8'h50, 1'b0);
        exp_v = ev(8'h40, 0, 0, 1, 4);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL overflow got %h want %h", obs, exp_v); end
        STEP = 1'b1;
        op(3'b001, 8'h77, 1'b0);
        tick();
        STEP = 1'b0;
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL fault_sticky got %h want %h", obs, exp_v); end
        do_reset();
        exp_v = ev(8'h00, 0, 1, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL fault_clear got %h want %h", obs, exp_v); end
        start_run();
        op(3'b101, 8'h00, 1'b0);
        exp_v = ev(8'h00, 0, 0, 1, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL underflow got %h want %h", obs, exp_v); end
    endtask
`else
    task automatic test_no_stack();
        do_reset();
        start_run();
        jmp(8'd3);
        for (int i = 0; i < 5; i++) begin
            op(3'b100, 8'h20 + 8'(i), 1'b0);
            exp_v = ev(8'h20 + 8'(i), 1, 0, 0, 0);
            checks++; if (obs !== exp_v) begin errors++; $display("FAIL call_as_jmp_%0d got %h want %h", i, obs, exp_v); end
        end
        op(3'b101, 8'h70, 1'b0);
        exp_v = ev(8'h25, 1, 0, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL ret_as_nop got %h want %h", obs, exp_v); end
    endtask
`endif

    task automatic test_halt_req();
        do_reset();
        start_run();
        jmp(8'd8);
        HALT_REQ = 1'b1;
        op(3'b001, 8'd50, 1'b0);
        exp_v = ev(8'd50, 0, 1, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL halt_req got %h want %h", obs, exp_v); end
        RUN = 1'b0;
        HALT_REQ = 1'b0;
        tick();
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL halt_hold got %h want %h", obs, exp_v); end
        RUN = 1'b1;
        tick();
        RUN = 1'b0;
        tick();
        exp_v = ev(8'd51, 0, 1, 0, 0);
        checks++; if (obs !== exp_v) begin errors++; $display("FAIL run_drop got %h want %h", obs, exp_v); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_step();
        test_branch();
`ifdef PC_SEQ_CALL_STACK_EN
        test_call_ret();
        test_faults();
`else
        test_no_stack();
`endif
        test_halt_req();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
